rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
// Shares the register file's single write port between two writeback sources.
// Port A is the ALU result path; port B is the load/memory return path.
// Performs round-robin arbitration with a valid/ready handshake, then registers
// the winning write onto the RF write port (we/wr_address/wr_data).
// The RF commits the write on the falling clk edge of that same cycle.
// Sits between the execute/memory stages and the register file.
// PARAMETERS
// DW   8  data width; matches the RF data width
// RFW  2  RF address width; the RF holds 2**RFW registers, and register 0 is hardwired to zero
// PORTS
// clk            in   1    clock; all state updates on the rising edge
// rst            in   1    asynchronous, active-high reset
// a_valid        in   1    port A has a write pending
// a_ready        out  1    port A write accepted this cycle
// a_address      in   RFW  port A destination register
// a_data         in   DW   port A write data
// b_valid        in   1    port B has a write pending
// b_ready        out  1    port B write accepted this cycle
// b_address      in   RFW  port B destination register
// b_data         in   DW   port B write data
// rf_we          out  1    RF write enable (registered)
// rf_wr_address  out  RFW  RF write address (registered)
// rf_wr_data     out  DW   RF write data (registered)
// busy           out  1    rf_we | a_valid | b_valid
// BEHAVIOUR
// - Reset values: rf_we=0, rf_wr_address=0, rf_wr_data=0, prio=A.
//   a_ready and b_ready are 0 while rst is high.
// - State: one-bit round-robin pointer prio (A or B) naming the preferred port.
// - Grant logic (combinational, from the current valids and prio):
//   - only one port valid -> that port is granted;
//   - both valid -> the port named by prio is granted;
//   - neither valid -> no grant.
//   - a_ready / b_ready = grant to A / B. At most one ready is high per cycle.
// - Handshake: a transfer occurs when valid && ready at the rising edge.
//   - The requester holds valid, address and data stable until ready.
//   - Dropping valid before ready is illegal; behaviour is undefined.
// - Rising edge with a transfer:
//   - rf_we <= (address != 0); rf_wr_address <= address; rf_wr_data <= data;
//   - prio <= the other port (the loser gets priority next).
// - Rising edge without a transfer: rf_we <= 0; address, data and prio hold.
// - Latency: accepted at edge N -> rf_we high during cycle N..N+1 -> RF commits
//   on the falling edge within that cycle. rf_we lasts exactly one cycle per
//   accepted write.
// - Writes to register 0 are accepted (ready=1) and prio advances, but rf_we
//   stays 0, so r0 is never written.
// - Back-to-back throughput: one write per cycle, with no bubbles.
// - Fairness: with both ports continuously valid, grants alternate
//   A,B,A,B...; no port waits more than one cycle.
// - Same-address collision: both ports target the same register in the same
//   cycle -> serialized; the later grant's data is final.
// - Reset mid-operation: rst clears rf_we immediately (asynchronously).
//   - A write registered but not yet committed at the falling edge is dropped.
//   - Requesters must re-present any write that was not acknowledged.
// - No combinational path from rf_* outputs back to the ready signals.
// TESTING
// 1 Reset: assert rst with both valids high -> rf_we=0, a_ready=b_ready=0,
//   outputs 0; after release, the first grant goes to A.
// 2 Single port: A writes r1=8'h3C -> a_ready=1 in the cycle, rf_we=1 the next
//   cycle with addr 1, data 3C; RF r1 reads 3C after the falling edge.
// 3 Contention: A and B both valid continuously (A->r1=11, B->r2=22) -> grants
//   A,B,A,B; rf_we stays high with no gaps.
// 4 Zero register: B writes r0=8'hFF -> b_ready=1, rf_we stays 0, and RF r0
//   reads 00.
// 5 Collision: A r3=AA and B r3=BB together with prio=A -> r3 reads AA, then BB
//   one cycle later.
// 6 Reset mid-write: assert rst between the rising and falling edge while
//   rf_we=1 -> rf_we drops at once; the RF register keeps its old value.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load-return (B) writeback paths; the winning write is registered onto rf_*.
module rf_write_arbiter #(
  parameter int DW  = 8,
  parameter int RFW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [RFW-1:0] a_address,
  input  logic [DW-1:0]  a_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [RFW-1:0] b_address,
  input  logic [DW-1:0]  b_data,
  output logic           rf_we,
  output logic [RFW-1:0] rf_wr_address,
  output logic [DW-1:0]  rf_wr_data,
  output logic           busy
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio;
  logic  grant_a;
  logic  grant_b;

  // Grants depend only on valids and prio, never on rf_*, so no loop back to ready.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && (!b_valid || prio == PRIO_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = rf_we | a_valid | b_valid;

  // Register 0 writes are acknowledged and advance prio but never assert rf_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we         <= 1'b0;
      rf_wr_address <= '0;
      rf_wr_data    <= '0;
      prio          <= PRIO_A;
    end else if (grant_a) begin
      rf_we         <= (a_address != '0);
      rf_wr_address <= a_address;
      rf_wr_data    <= a_data;
      prio          <= PRIO_B;
    end else if (grant_b) begin
      rf_we         <= (b_address != '0);
      rf_wr_address <= b_address;
      rf_wr_data    <= b_data;
      prio          <= PRIO_A;
    end else begin
      rf_we         <= 1'b0;
    end
  end

endmodule
